// File: rtl/mpsoc_multi_timer.sv
// Multi-channel interval timer on an Avalon-MM slave port: NUM_CH down-counters that share
// one prescaler tick. Each channel's timeout can raise the single irq output.
module mpsoc_multi_timer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PRE_W      = 16,
  parameter int ADDR_W     = 6,
  parameter int PERIOD_RST = 49999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] ADDR_PEND = ADDR_W'(4 * NUM_CH);
  localparam logic [ADDR_W-1:0] ADDR_PRE  = ADDR_W'(4 * NUM_CH + 1);
  localparam logic [CNT_W-1:0]  CNT_RST   = CNT_W'(PERIOD_RST);

  logic              wr;
  logic [PRE_W-1:0]  prescale;
  logic [PRE_W-1:0]  divider;
  logic              tick;

  logic [NUM_CH-1:0] to;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] ito;
  logic [NUM_CH-1:0] cont;
  logic [NUM_CH-1:0] force_reload;
  logic [NUM_CH-1:0] pend;
  logic [CNT_W-1:0]  period  [NUM_CH];
  logic [CNT_W-1:0]  counter [NUM_CH];
  logic [CNT_W-1:0]  snap    [NUM_CH];

  logic [NUM_CH-1:0] wr_status;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_period;
  logic [NUM_CH-1:0] wr_snap;
  logic [NUM_CH-1:0] timeout;
  logic [31:0]       rd_next;

  assign wr   = chipselect & ~write_n;
  assign tick = (divider == prescale);
  assign pend = to & ito;
  assign irq  = |pend;

  always_comb begin
    wr_status = '0;
    wr_ctrl   = '0;
    wr_period = '0;
    wr_snap   = '0;
    timeout   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_status[c] = wr && (address == ADDR_W'(4 * c));
      wr_ctrl[c]   = wr && (address == ADDR_W'(4 * c + 1));
      wr_period[c] = wr && (address == ADDR_W'(4 * c + 2));
      wr_snap[c]   = wr && (address == ADDR_W'(4 * c + 3));
      timeout[c]   = run[c] && tick && (counter[c] == '0);
    end
  end

  // Writing PRESCALE restarts the divider so the first tick comes a full interval later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      divider  <= '0;
    end else begin
      if (wr && (address == ADDR_PRE)) begin
        prescale <= writedata[PRE_W-1:0];
        divider  <= '0;
      end else if (tick) begin
        divider <= '0;
      end else begin
        divider <= divider + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        to[c]           <= 1'b0;
        run[c]          <= 1'b0;
        ito[c]          <= 1'b0;
        cont[c]         <= 1'b0;
        force_reload[c] <= 1'b0;
        period[c]       <= CNT_RST;
        counter[c]      <= CNT_RST;
        snap[c]         <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        force_reload[c] <= wr_period[c];

        // A timeout in the same cycle as a STATUS write must not be lost.
        if (timeout[c]) begin
          to[c] <= 1'b1;
        end else if (wr_status[c]) begin
          to[c] <= 1'b0;
        end

        if (wr_ctrl[c]) begin
          cont[c] <= writedata[1];
          ito[c]  <= writedata[0];
        end

        if (wr_period[c]) begin
          run[c] <= 1'b0;
        end else if (wr_ctrl[c] && writedata[2]) begin
          run[c] <= 1'b1;
        end else if (wr_ctrl[c] && writedata[3]) begin
          run[c] <= 1'b0;
        end else if (timeout[c] && !cont[c]) begin
          run[c] <= 1'b0;
        end

        if (wr_period[c]) begin
          period[c] <= writedata[CNT_W-1:0];
        end

        // A new period is loaded one edge after it was written; on the write edge itself the
        // counter holds so no stale wrap reload can race with it.
        if (force_reload[c]) begin
          counter[c] <= period[c];
        end else if (wr_period[c]) begin
          counter[c] <= counter[c];
        end else if (timeout[c]) begin
          counter[c] <= period[c];
        end else if (run[c] && tick) begin
          counter[c] <= counter[c] - CNT_W'(1);
        end

        if (wr_snap[c]) begin
          snap[c] <= counter[c];
        end
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (address == ADDR_W'(4 * c)) begin
        rd_next = {30'd0, run[c], to[c]};
      end else if (address == ADDR_W'(4 * c + 1)) begin
        rd_next = {30'd0, cont[c], ito[c]};
      end else if (address == ADDR_W'(4 * c + 2)) begin
        rd_next = 32'(period[c]);
      end else if (address == ADDR_W'(4 * c + 3)) begin
        rd_next = 32'(snap[c]);
      end
    end
    if (address == ADDR_PEND) begin
      rd_next = 32'(pend);
    end
    if (address == ADDR_PRE) begin
      rd_next = 32'(prescale);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_mpsoc_multi_timer.sv
// Self-checking bench for mpsoc_multi_timer: directed register/timing scenarios plus
// randomized one-shot/continuous runs checked against an arithmetic timeout-latency model.
module tb_mpsoc_multi_timer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int PRE_W  = 16;
  localparam int ADDR_W = 6;
  localparam int PRST   = 49999;
  localparam int A_PEND = 16;
  localparam int A_PRE  = 17;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mpsoc_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W), .ADDR_W(ADDR_W), .PERIOD_RST(PRST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic applyStimulus(input int addr, input logic [31:0] data);
    address    = ADDR_W'(addr);
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input int addr, output logic [31:0] d);
    address    = ADDR_W'(addr);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  // Edges from the START edge until TO is visible: the divider is 0 after the PRESCALE write,
  // so it holds (1 mod (pre+1)) after START; the (per+1)-th tick sets TO.
  function automatic int expectedTimeout(input int per, input int pre);
    int d0;
    d0 = (pre == 0) ? 0 : 1;
    return (pre - d0) + per * (pre + 1) + 1;
  endfunction

  task automatic runTimeout(input int ch, input int per, input int pre, input int cnt,
                            output int j);
    applyStimulus(4 * ch + 2, 32'(per));
    applyStimulus(4 * ch, 32'd0);
    applyStimulus(A_PRE, 32'(pre));
    applyStimulus(4 * ch + 1, 32'(5 | (cnt << 1)));
    j = 0;
    while (!irq && j < 1000) begin
      @(negedge clk);
      j++;
    end
    checkOutput($sformatf("ch%0d per=%0d pre=%0d timeout latency", ch, per, pre), 32'(j),
                32'(expectedTimeout(per, pre)));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int j, e1, c, prev, nd, exp_snap;
    bit skip, irq_hi;
    int exp_rst [4];

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput("reset irq", 32'(irq), 32'd0);
    exp_rst = '{0, 0, PRST, 0};
    for (int a = 0; a < 4; a++) begin
      readReg(a, d);
      checkOutput($sformatf("reset addr%0d", a), d, 32'(exp_rst[a]));
    end
    readReg(A_PEND, d);
    checkOutput("reset irq_pend", d, 32'd0);
    readReg(A_PRE, d);
    checkOutput("reset prescale", d, 32'd0);

    $display("[TB] ch0 one-shot");
    runTimeout(0, 4, 0, 0, j);
    checkOutput("ch0 latency is 5", 32'(j), 32'd5);
    readReg(0, d);
    checkOutput("ch0 status after one-shot", d, 32'd1);
    applyStimulus(0, 32'd0);
    checkOutput("ch0 irq cleared by status write", 32'(irq), 32'd0);

    $display("[TB] ch1 continuous, prescale 3, ITO off");
    applyStimulus(6, 32'd2);
    applyStimulus(4, 32'd0);
    applyStimulus(A_PRE, 32'd3);
    applyStimulus(5, 32'h6);
    e1 = cyc; prev = e1; nd = 0; skip = 1'b0; irq_hi = 1'b0;
    address = ADDR_W'(4); writedata = '0; chipselect = 1'b1; write_n = 1'b1;
    for (int k = 0; k < 100 && nd < 3; k++) begin
      @(negedge clk);
      if (irq) irq_hi = 1'b1;
      if (skip) begin
        skip    = 1'b0;
        write_n = 1'b1;
      end else if (readdata[0]) begin
        nd++;
        checkOutput($sformatf("ch1 timeout %0d spacing", nd), 32'(cyc - prev), 32'd12);
        prev = cyc;
        if (nd == 3) checkOutput("ch1 status run+to", readdata, 32'd3);
        else begin
          write_n = 1'b0;
          skip    = 1'b1;
        end
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
    checkOutput("ch1 timeouts seen", 32'(nd), 32'd3);
    checkOutput("ch1 irq stays low", 32'(irq_hi), 32'd0);
    readReg(A_PEND, d);
    checkOutput("ch1 irq_pend masked", d, 32'd0);
    applyStimulus(5, 32'h8);
    applyStimulus(4, 32'd0);

    $display("[TB] ch2 snapshot and period rewrite");
    applyStimulus(10, 32'd100);
    applyStimulus(A_PRE, 32'd0);
    applyStimulus(9, 32'h4);
    e1 = cyc;
    repeat ($urandom_range(5, 40)) @(negedge clk);
    c = cyc;
    exp_snap = 100 - (c - e1);
    applyStimulus(11, 32'd0);
    readReg(11, d);
    checkOutput("ch2 snap mid-count", d, 32'(exp_snap));
    applyStimulus(10, 32'd10);
    readReg(8, d);
    checkOutput("ch2 status after period write", d, 32'd0);
    applyStimulus(11, 32'd0);
    readReg(11, d);
    checkOutput("ch2 counter reloaded to 10", d, 32'd10);
    readReg(10, d);
    checkOutput("ch2 period readback", d, 32'd10);

    $display("[TB] ch3 status write colliding with timeout");
    applyStimulus(14, 32'd3);
    applyStimulus(12, 32'd0);
    applyStimulus(13, 32'h5);
    e1 = cyc;
    while (cyc < e1 + 3) @(negedge clk);
    applyStimulus(12, 32'd0);
    checkOutput("ch3 irq after collision", 32'(irq), 32'd1);
    readReg(12, d);
    checkOutput("ch3 status after collision", d, 32'd1);
    applyStimulus(13, 32'hC);
    readReg(12, d);
    checkOutput("ch3 start wins over stop", d, 32'd3);

    $display("[TB] randomized timeouts");
    for (int it = 0; it < 10; it++) begin
      int ch, per, pre, cnt;
      ch  = $urandom_range(0, NUM_CH - 1);
      per = $urandom_range(0, 20);
      pre = $urandom_range(0, 5);
      cnt = $urandom_range(0, 1);
      runTimeout(ch, per, pre, cnt, j);
      readReg(4 * ch, d);
      checkOutput($sformatf("rand ch%0d status cont=%0d", ch, cnt), d, 32'((cnt << 1) | 1));
      readReg(A_PEND, d);
      checkOutput($sformatf("rand ch%0d irq_pend", ch), d, 32'(1 << ch));
      applyStimulus(4 * ch + 1, 32'h8);
      applyStimulus(4 * ch, 32'd0);
      checkOutput($sformatf("rand ch%0d irq after clear", ch), 32'(irq), 32'd0);
    end

    $display("[TB] asynchronous reset mid-count");
    applyStimulus(A_PRE, 32'd0);
    for (int ch = 1; ch < NUM_CH; ch++) begin
      applyStimulus(4 * ch + 2, 32'd1000);
      applyStimulus(4 * ch + 1, 32'h4);
    end
    applyStimulus(2, 32'd2);
    applyStimulus(0, 32'd0);
    applyStimulus(1, 32'h7);
    j = 0;
    while (!irq && j < 100) begin
      @(negedge clk);
      j++;
    end
    checkOutput("irq before reset", 32'(irq), 32'd1);
    readReg(2, d);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("irq drops asynchronously", 32'(irq), 32'd0);
    checkOutput("readdata drops asynchronously", readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int n = 0; n < 4; n++) begin
        readReg(4 * ch + n, d);
        checkOutput($sformatf("post-reset ch%0d reg%0d", ch, n), d, 32'(exp_rst[n]));
      end
      applyStimulus(4 * ch + 3, 32'd0);
      readReg(4 * ch + 3, d);
      checkOutput($sformatf("post-reset ch%0d counter", ch), d, 32'(PRST));
    end
    readReg(A_PEND, d);
    checkOutput("post-reset irq_pend", d, 32'd0);
    readReg(A_PRE, d);
    checkOutput("post-reset prescale", d, 32'd0);
    checkOutput("post-reset irq", 32'(irq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
